seg14_scroll_mux: RTL

Parametrised multiplexed 14-segment display driver that scans `DIGITS` common-select lines and shows a run-time loadable message with optional horizontal scrolling. It replaces fixed-text display drivers: the host writes raw 14-bit segment patterns into an internal message buffer and sets the message length, and the block handles digit dwell timing, digit select, wrap-around and scroll stepping. It sits between the user-logic register interface and the display pads.

---
 rtl/seg14_scroll_mux.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/seg14_scroll_mux.sv
// seg14_scroll_mux
// ----------------
// Multiplexed 14-segment display driver with a run-time loadable message
// buffer and optional horizontal scrolling.
//
// The host writes raw 14-bit segment patterns into the message buffer and
// sets the active message length. The block scans DIGITS one-hot select
// lines. Each digit is held for DWELL cycles. When the message is shorter
// than the display, the message wraps across the digits. When scrolling is
// enabled, the start of the message steps by one character every
// SCROLL_FRAMES full scan frames.
//
// Parameters
//   DIGITS        number of display digits (width of sel), >= 1
//   MSG_DEPTH     message buffer entries, >= 1
//   DWELL         clock cycles each digit is held, >= 1
//   SCROLL_FRAMES full frames per one-character scroll step, >= 1
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears outputs, counters
//              and the whole message buffer
//   wr_en      message buffer write strobe
//   wr_addr    buffer entry to write; addresses >= MSG_DEPTH are ignored
//   wr_data    raw segment pattern, same bit order as segm
//   msg_len    active message length; values above MSG_DEPTH are clamped
//   scroll_en  1 = scroll one character every SCROLL_FRAMES frames
//   sel        registered one-hot digit select
//   segm       registered segment pattern for the selected digit
//   frame_tick one-cycle pulse during the final cycle of each frame

module seg14_scroll_mux #(
  parameter int DIGITS        = 12,
  parameter int MSG_DEPTH     = 32,
  parameter int DWELL         = 1,
  parameter int SCROLL_FRAMES = 64,
  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1,
  localparam int LW = $clog2(MSG_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [13:0]       wr_data,
  input  logic [LW-1:0]     msg_len,
  input  logic              scroll_en,
  output logic [DIGITS-1:0] sel,
  output logic [13:0]       segm,
  output logic              frame_tick
);

  localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int DGW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FCW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  typedef logic [DWW-1:0]    dwell_t;
  typedef logic [DGW-1:0]    digit_t;
  typedef logic [FCW-1:0]    frame_t;
  typedef logic [AW-1:0]     idx_t;
  typedef logic [LW-1:0]     len_t;
  // One bit wider than a length so that "index + 1" never overflows when it
  // is compared against the active length.
  typedef logic [LW:0]       lenx_t;
  typedef logic [DIGITS-1:0] sel_t;

  localparam dwell_t DWELL_LAST = dwell_t'(DWELL - 1);
  localparam digit_t DIGIT_LAST = digit_t'(DIGITS - 1);
  localparam frame_t FRAME_LAST = frame_t'(SCROLL_FRAMES - 1);
  localparam len_t   DEPTH_LEN  = len_t'(MSG_DEPTH);
  localparam lenx_t  DEPTH_X    = lenx_t'(MSG_DEPTH);

  // Scan state
  dwell_t dwell_cnt, dwell_cnt_nxt;
  digit_t digit,     digit_nxt;
  frame_t frame_cnt, frame_cnt_nxt;
  idx_t   ptr,       ptr_nxt;
  idx_t   offset,    offset_nxt;
  logic   tick_nxt;

  // Message storage
  logic [13:0] msg_buf     [MSG_DEPTH];
  logic [13:0] msg_buf_nxt [MSG_DEPTH];
  logic [13:0] rd_data;
  logic        wr_ok;

  // Derived length and step helpers
  len_t   len_eff;
  lenx_t  len_x;
  logic   len_zero;
  logic   dwell_last;
  logic   digit_last;
  logic   frame_last;
  idx_t   ptr_step;
  idx_t   offset_step;

  // The host may program a length larger than the buffer; anything beyond
  // MSG_DEPTH behaves as a full-buffer message.
  always_comb begin
    len_eff  = (msg_len > DEPTH_LEN) ? DEPTH_LEN : msg_len;
    len_x    = lenx_t'(len_eff);
    len_zero = (len_eff == '0);
  end

  // Writes beyond the buffer are dropped here so that a wide address bus
  // with a non-power-of-two depth never touches a non-existent entry.
  always_comb begin
    wr_ok       = wr_en && (lenx_t'(wr_addr) < DEPTH_X);
    msg_buf_nxt = msg_buf;
    if (wr_ok) begin
      msg_buf_nxt[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_buf <= '{default: '0};
    end else begin
      msg_buf <= msg_buf_nxt;
    end
  end

  // ptr never exceeds the largest length seen, which is bounded by
  // MSG_DEPTH, so this read always lands on a real entry.
  assign rd_data = msg_buf[ptr];

  // Wrap-aware successors of the read pointer and the scroll offset. A
  // value that is already at or past the active length (possible right
  // after msg_len shrinks) also wraps to the start of the message.
  always_comb begin
    ptr_step    = ((lenx_t'(ptr) + lenx_t'(1)) >= len_x) ? '0 : ptr + idx_t'(1);
    offset_step = ((lenx_t'(offset) + lenx_t'(1)) >= len_x) ? '0 : offset + idx_t'(1);
  end

  // Next-state for the scan. The dwell counter runs every cycle; only its
  // wrap moves the digit. Within a frame the pointer walks the message.
  // At the end of a frame the pointer restarts from the (possibly stepped
  // or corrected) scroll offset, so a shortened message is re-aligned at
  // the next frame boundary at the latest.
  always_comb begin
    dwell_last    = (dwell_cnt == DWELL_LAST);
    digit_last    = (digit == DIGIT_LAST);
    frame_last    = (frame_cnt == FRAME_LAST);

    dwell_cnt_nxt = dwell_last ? '0 : dwell_cnt + dwell_t'(1);
    digit_nxt     = digit;
    frame_cnt_nxt = frame_cnt;
    ptr_nxt       = ptr;
    offset_nxt    = offset;
    tick_nxt      = 1'b0;

    if (dwell_last) begin
      if (!digit_last) begin
        digit_nxt = digit + digit_t'(1);
        ptr_nxt   = ptr_step;
      end else begin
        digit_nxt     = '0;
        tick_nxt      = 1'b1;
        frame_cnt_nxt = frame_last ? '0 : frame_cnt + frame_t'(1);
        if (frame_last && scroll_en) begin
          offset_nxt = offset_step;
        end else if (lenx_t'(offset) >= len_x) begin
          offset_nxt = '0;
        end
        ptr_nxt = offset_nxt;
      end
    end

    // An empty message pins both indices at the start so the first
    // character shows correctly as soon as a length is programmed.
    if (len_zero) begin
      ptr_nxt    = '0;
      offset_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      digit     <= '0;
      frame_cnt <= '0;
      ptr       <= '0;
      offset    <= '0;
    end else begin
      dwell_cnt <= dwell_cnt_nxt;
      digit     <= digit_nxt;
      frame_cnt <= frame_cnt_nxt;
      ptr       <= ptr_nxt;
      offset    <= offset_nxt;
    end
  end

  // Outputs reflect the scan state one cycle later. Because frame_tick is
  // registered from the same edge that wraps the digit, it is high while
  // the last digit is still displayed, i.e. in the frame's final cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= '0;
      segm       <= '0;
      frame_tick <= 1'b0;
    end else begin
      sel        <= sel_t'(1) << digit;
      segm       <= len_zero ? 14'h0000 : rd_data;
      frame_tick <= tick_nxt;
    end
  end

endmodule
